// File: rtl/clk_meter_pkg.sv
// Shared definitions for the clock period meter: FSM state encoding,
// warm-up length and the default counter width.
package clk_meter_pkg;

    localparam int CNT_W_DEF  = 24;
    localparam int WARMUP_CYC = 3;

    typedef logic [1:0] state_t;

    localparam state_t WARMUP = 2'd0;
    localparam state_t IDLE   = 2'd1;
    localparam state_t ARM    = 2'd2;
    localparam state_t MEAS   = 2'd3;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a delay register, producing one-cycle
// rise/fall strobes for an asynchronous level. Synchronous active-high reset
// clears the whole chain, so no edge is reported out of reset unless the
// input is actually high.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic dly;

    // Synchronizer and delay pipeline.
    // NOTE: non-blocking assignments make each stage take the previous
    // stage's old value, which is what turns these three lines into a shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            dly  <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            dly  <= sync;
        end
    end

    assign rise = sync & ~dly;
    assign fall = ~sync & dly;

endmodule

// File: rtl/clk_period_meter.sv
// One-shot period / high-time meter for a slow divided clock, counted in
// CLK_IN cycles. A START pulse arms the meter, the first conditioned rising
// edge of SIG_IN starts the count and the next one ends it with VALID.
// A stalled SIG_IN is caught by a watchdog on the same counter (TIMEOUT).
//
// Build option: define CLK_METER_DUTY_EN to build falling-edge detection and
// the HIGH_TIME register; otherwise HIGH_TIME is tied to zero.
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT_CYC = {CNT_W{1'b1}}
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             SIG_IN,
    input  logic             START,
    output logic             BUSY,
    output logic             VALID,
    output logic             TIMEOUT,
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] HIGH_TIME
);

    state_t           state;
    logic [1:0]       warm_cnt;
    logic [CNT_W-1:0] cnt;
    logic             rise;

`ifdef CLK_METER_DUTY_EN
    logic fall;

    sync_edge_det u_sync (
        .clk  (CLK_IN),
        .rst  (RST),
        .din  (SIG_IN),
        .rise (rise),
        .fall (fall)
    );
`else
    logic fall_unused;

    sync_edge_det u_sync (
        .clk  (CLK_IN),
        .rst  (RST),
        .din  (SIG_IN),
        .rise (rise),
        .fall (fall_unused)
    );
`endif

    // Busy everywhere except IDLE; this drops in the same cycle as VALID/TIMEOUT
    // because the FSM returns to IDLE on the edge that raises the strobe.
    assign BUSY = (state != IDLE);

    // Measurement FSM, shared period/watchdog counter and PERIOD register.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            state    <= WARMUP;
            warm_cnt <= '0;
            cnt      <= '0;
            VALID    <= 1'b0;
            TIMEOUT  <= 1'b0;
            PERIOD   <= '0;
        end else begin
            VALID   <= 1'b0;
            TIMEOUT <= 1'b0;
            case (state)
                WARMUP: begin
                    if (warm_cnt == 2'(WARMUP_CYC - 1)) begin
                        state <= IDLE;
                    end else begin
                        warm_cnt <= warm_cnt + 2'd1;
                    end
                end
                IDLE: begin
                    // A START coinciding with a result strobe is dropped so that
                    // a requester reacting to the strobe cannot double-trigger.
                    if (START && !VALID && !TIMEOUT) begin
                        cnt   <= '0;
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (rise) begin
                        cnt   <= CNT_W'(1);
                        state <= MEAS;
                    end else if (cnt == TIMEOUT_CYC) begin
                        TIMEOUT <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                MEAS: begin
                    if (rise) begin
                        PERIOD <= cnt;
                        VALID  <= 1'b1;
                        state  <= IDLE;
                    end else if (cnt == TIMEOUT_CYC) begin
                        TIMEOUT <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= WARMUP;
            endcase
        end
    end

`ifdef CLK_METER_DUTY_EN
    logic fall_seen;

    // Capture the count at the first falling edge after the starting rise;
    // later falls (glitches) and a missing fall leave HIGH_TIME untouched.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            HIGH_TIME <= '0;
            fall_seen <= 1'b0;
        end else if (state == ARM && rise) begin
            fall_seen <= 1'b0;
        end else if (state == MEAS && fall && !fall_seen) begin
            HIGH_TIME <= cnt;
            fall_seen <= 1'b1;
        end
    end
`else
    assign HIGH_TIME = '0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter (CNT_W = 8, TIMEOUT_CYC = 50).
// Expected results are queued when a measurement is started and compared by a
// negedge monitor whenever VALID or TIMEOUT is seen.
module tb_clk_period_meter;

    localparam int CNT_W = 8;
    localparam int TO    = 50;
`ifdef CLK_METER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    typedef struct {
        bit is_timeout;
        int p_lo;
        int p_hi;
        int h_lo;
        int h_hi;
    } exp_t;

    logic             CLK_IN = 1'b0;
    logic             RST    = 1'b1;
    logic             SIG_IN = 1'b0;
    logic             START  = 1'b0;
    logic             BUSY;
    logic             VALID;
    logic             TIMEOUT;
    logic [CNT_W-1:0] PERIOD;
    logic [CNT_W-1:0] HIGH_TIME;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // 0: SIG_IN low, 1: synchronous divider sig_hi/sig_lo, 2: async 37.3-cycle period
    int sig_mode = 0;
    int sig_hi   = 5;
    int sig_lo   = 5;
    int ph       = 0;

    clk_period_meter #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (8'(TO))
    ) dut (
        .CLK_IN    (CLK_IN),
        .RST       (RST),
        .SIG_IN    (SIG_IN),
        .START     (START),
        .BUSY      (BUSY),
        .VALID     (VALID),
        .TIMEOUT   (TIMEOUT),
        .PERIOD    (PERIOD),
        .HIGH_TIME (HIGH_TIME)
    );

    always #5 CLK_IN = ~CLK_IN;

    // Slow clock generator.
    always begin
        if (sig_mode == 2) begin
            SIG_IN = 1'b1;
            #186;
            SIG_IN = 1'b0;
            #187;
        end else begin
            @(posedge CLK_IN);
            #1;
            if (sig_mode == 1) begin
                SIG_IN = (ph < sig_hi);
                ph     = (ph + 1 >= sig_hi + sig_lo) ? 0 : ph + 1;
            end else begin
                SIG_IN = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge CLK_IN) begin : monitor
        exp_t e;
        if (VALID === 1'b1 || TIMEOUT === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result valid=%0b timeout=%0b required none", VALID, TIMEOUT);
            end else begin
                e = sb.pop_front();
                checks++;
                if (e.is_timeout ? !(TIMEOUT === 1'b1 && VALID === 1'b0)
                                 : !(VALID === 1'b1 && TIMEOUT === 1'b0)) begin
                    failures++;
                    $display("FAIL result_kind valid=%0b timeout=%0b required_timeout=%0b",
                             VALID, TIMEOUT, e.is_timeout);
                end
                checks++;
                if ($isunknown(PERIOD) || int'(PERIOD) < e.p_lo || int'(PERIOD) > e.p_hi) begin
                    failures++;
                    $display("FAIL period got=%0d required=[%0d:%0d]", PERIOD, e.p_lo, e.p_hi);
                end
                checks++;
                if ($isunknown(HIGH_TIME) || int'(HIGH_TIME) < e.h_lo || int'(HIGH_TIME) > e.h_hi) begin
                    failures++;
                    $display("FAIL high_time got=%0d required=[%0d:%0d]", HIGH_TIME, e.h_lo, e.h_hi);
                end
            end
        end
    end

    task automatic push_exp(input bit is_to, input int p_lo, input int p_hi, input int h_lo, input int h_hi);
        exp_t e;
        e.is_timeout = is_to;
        e.p_lo = p_lo;
        e.p_hi = p_hi;
        e.h_lo = h_lo;
        e.h_hi = h_hi;
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        @(posedge CLK_IN);
        #1 START = 1'b1;
        @(posedge CLK_IN);
        #1 START = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            @(negedge CLK_IN);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_done pending=%0d required=0 within %0d cycles", name, sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic set_sync(input int hi, input int lo);
        sig_hi   = hi;
        sig_lo   = lo;
        ph       = 0;
        sig_mode = 1;
        repeat (3 * (hi + lo)) @(posedge CLK_IN);
    endtask

    task automatic test_reset();
        int busy_seen;
        START = 1'b0;
        RST   = 1'b1;
        repeat (2) @(posedge CLK_IN);
        #1;
        checks += 5;
        if (BUSY !== 1'b1)   begin failures++; $display("FAIL rst_busy got=%b required=1", BUSY); end
        if (VALID !== 1'b0)  begin failures++; $display("FAIL rst_valid got=%b required=0", VALID); end
        if (TIMEOUT !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%b required=0", TIMEOUT); end
        if (PERIOD !== '0)   begin failures++; $display("FAIL rst_period got=%0d required=0", PERIOD); end
        if (HIGH_TIME !== '0) begin failures++; $display("FAIL rst_high got=%0d required=0", HIGH_TIME); end
        RST = 1'b0;
        // BUSY high for exactly three cycles; START in the window must be ignored.
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK_IN);
            checks++;
            if (BUSY !== (i < 3)) begin
                failures++;
                $display("FAIL warmup_busy cycle=%0d got=%b required=%b", i, BUSY, (i < 3));
            end
            START = (i == 1);
        end
        START = 1'b0;
        busy_seen = 0;
        repeat (12) begin
            @(negedge CLK_IN);
            if (BUSY !== 1'b0) busy_seen++;
        end
        checks++;
        if (busy_seen != 0) begin
            failures++;
            $display("FAIL warmup_start_ignored busy_cycles=%0d required=0", busy_seen);
        end
    endtask

    task automatic test_div10();
        set_sync(5, 5);
        push_exp(1'b0, 10, 10, DUTY ? 5 : 0, DUTY ? 5 : 0);
        pulse_start();
        checks++;
        if (BUSY !== 1'b1) begin failures++; $display("FAIL div10_busy_after_start got=%b required=1", BUSY); end
        wait_done(100, "div10");
        checks++;
        if (BUSY !== 1'b0) begin failures++; $display("FAIL div10_busy_after_valid got=%b required=0", BUSY); end
    endtask

    task automatic test_back_to_back();
        bool_wait : begin end
        set_sync(3, 4);
        repeat (3) push_exp(1'b0, 7, 7, DUTY ? 3 : 0, DUTY ? 3 : 0);
        pulse_start();
        for (int run = 0; run < 3; run++) begin
            int  n;
            bit  seen;
            seen = 1'b0;
            for (n = 0; n < 100; n++) begin
                @(negedge CLK_IN);
                if (VALID === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            checks++;
            if (!seen) begin
                failures++;
                $display("FAIL b2b_valid run=%0d got=none required=valid within 100 cycles", run);
            end
            if (run < 2) begin
                pulse_start();
                checks++;
                if (BUSY !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_restart run=%0d busy=%b required=1", run, BUSY);
                end
            end
        end
        wait_done(5, "b2b");
    endtask

    task automatic test_timeout();
        int  k;
        bit  seen;
        bit  busy_first;
        sig_mode = 0;
        repeat (6) @(posedge CLK_IN);
        push_exp(1'b1, 7, 7, DUTY ? 3 : 0, DUTY ? 3 : 0);
        pulse_start();
        seen = 1'b0;
        busy_first = 1'b0;
        for (k = 0; k < 120; k++) begin
            @(negedge CLK_IN);
            if (k == 0) busy_first = BUSY;
            if (TIMEOUT === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks += 3;
        if (busy_first !== 1'b1) begin failures++; $display("FAIL to_busy_arm got=%b required=1", busy_first); end
        if (!seen || k != TO + 1) begin
            failures++;
            $display("FAIL to_latency got=%0d required=%0d", seen ? k : -1, TO + 1);
        end
        if (BUSY !== 1'b0) begin failures++; $display("FAIL to_busy got=%b required=0", BUSY); end
        wait_done(5, "timeout");
    endtask

    task automatic test_reset_mid();
        set_sync(5, 5);
        @(negedge SIG_IN);
        pulse_start();
        repeat (8) @(posedge CLK_IN);
        #1 RST = 1'b1;
        repeat (2) @(posedge CLK_IN);
        #1;
        checks += 3;
        if (PERIOD !== '0) begin failures++; $display("FAIL mid_rst_period got=%0d required=0", PERIOD); end
        if (HIGH_TIME !== '0) begin failures++; $display("FAIL mid_rst_high got=%0d required=0", HIGH_TIME); end
        if (BUSY !== 1'b1) begin failures++; $display("FAIL mid_rst_busy got=%b required=1", BUSY); end
        RST = 1'b0;
        repeat (5) @(posedge CLK_IN);
        push_exp(1'b0, 10, 10, DUTY ? 5 : 0, DUTY ? 5 : 0);
        pulse_start();
        wait_done(100, "after_reset");
    endtask

    task automatic test_async();
        sig_mode = 2;
        repeat (50) @(posedge CLK_IN);
        for (int run = 0; run < 100; run++) begin
            push_exp(1'b0, 37, 38, DUTY ? 18 : 0, DUTY ? 19 : 0);
            pulse_start();
            wait_done(150, "async");
        end
    endtask

    initial begin
        test_reset();
        test_div10();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_async();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout reached required=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
